// File: rtl/mem_io_bridge_if.sv
// CPU byte port plus RAM word port of mem_io_bridge. The bridge takes the slave view.
// The master view belongs to the CPU/RAM side. MEM_IO_ALIGN_TRAP_EN adds CPUfault.
interface mem_io_bridge_if #(parameter int ADDR_W = 16);
    logic              CPUreq;
    logic              CPUwe;
    logic [1:0]        CPUbe;
    logic [ADDR_W-1:0] CPUaddr;
    logic [15:0]       CPUwrite;
    logic [15:0]       CPUread;
    logic              CPUack;
    logic              CPUbusy;
`ifdef MEM_IO_ALIGN_TRAP_EN
    logic              CPUfault;
`endif
    logic              RAMreq;
    logic              RAMwe;
    logic [1:0]        RAMbe;
    logic [ADDR_W-1:0] RAMaddr;
    logic [15:0]       RAMwrite;
    logic [15:0]       RAMread;

    modport slave (
        input  CPUreq, CPUwe, CPUbe, CPUaddr, CPUwrite, RAMread,
`ifdef MEM_IO_ALIGN_TRAP_EN
        output CPUfault,
`endif
        output CPUread, CPUack, CPUbusy,
        output RAMreq, RAMwe, RAMbe, RAMaddr, RAMwrite
    );

    modport master (
        output CPUreq, CPUwe, CPUbe, CPUaddr, CPUwrite, RAMread,
`ifdef MEM_IO_ALIGN_TRAP_EN
        input  CPUfault,
`endif
        input  CPUread, CPUack, CPUbusy,
        input  RAMreq, RAMwe, RAMbe, RAMaddr, RAMwrite
    );
endinterface

// File: rtl/mem_io_bridge.sv
// Converts byte-addressed CPU requests into word-addressed RAM cycles with RAM_LAT read latency.
// Odd word accesses are split in two; with MEM_IO_ALIGN_TRAP_EN defined they fault instead.
module mem_io_bridge #(
    parameter int ADDR_W  = 16,
    parameter int RAM_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_io_bridge_if.slave bus
);
    localparam int WA_W = ADDR_W - 1;

    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE} state_t;

    state_t          state;
    logic            we_q, byte_q, odd_q, split_q;
    logic [WA_W-1:0] wa_q;
    logic [15:0]     wd_q;
    logic [7:0]      hi_q;
    logic [2:0]      cnt;
    logic            lat_end, req_byte, req_split;
    logic [1:0]      be0;
    logic [15:0]     wd0, rd_single;

    assign lat_end   = (cnt == 3'(RAM_LAT - 1));
    assign req_byte  = (bus.CPUbe == 2'b01);
    assign req_split = !req_byte && bus.CPUaddr[0];

    // First RAM access built straight from the request so RAMreq can rise the next cycle.
    always_comb begin
        be0 = 2'b11;
        wd0 = bus.CPUwrite;
        if (req_byte) begin
            be0 = bus.CPUaddr[0] ? 2'b01 : 2'b10;
            wd0 = bus.CPUaddr[0] ? {8'h00, bus.CPUwrite[7:0]} : {bus.CPUwrite[7:0], 8'h00};
        end else if (bus.CPUaddr[0]) begin
            be0 = 2'b01;
            wd0 = {8'h00, bus.CPUwrite[15:8]};
        end
    end

    always_comb begin
        rd_single = bus.RAMread;
        if (byte_q)
            rd_single = odd_q ? {8'h00, bus.RAMread[7:0]} : {8'h00, bus.RAMread[15:8]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            byte_q       <= 1'b0;
            odd_q        <= 1'b0;
            split_q      <= 1'b0;
            wa_q         <= '0;
            wd_q         <= '0;
            hi_q         <= '0;
            cnt          <= '0;
            bus.CPUread  <= '0;
            bus.CPUack   <= 1'b0;
            bus.CPUbusy  <= 1'b0;
`ifdef MEM_IO_ALIGN_TRAP_EN
            bus.CPUfault <= 1'b0;
`endif
            bus.RAMreq   <= 1'b0;
            bus.RAMwe    <= 1'b0;
            bus.RAMbe    <= '0;
            bus.RAMaddr  <= '0;
            bus.RAMwrite <= '0;
        end else begin
            case (state)
                IDLE: if (bus.CPUreq) begin
                    we_q        <= bus.CPUwe;
                    byte_q      <= req_byte;
                    odd_q       <= bus.CPUaddr[0];
                    split_q     <= req_split;
                    wa_q        <= bus.CPUaddr[ADDR_W-1:1];
                    wd_q        <= bus.CPUwrite;
                    bus.CPUbusy <= 1'b1;
`ifdef MEM_IO_ALIGN_TRAP_EN
                    if (req_split) begin
                        state        <= DONE;
                        bus.CPUack   <= 1'b1;
                        bus.CPUfault <= 1'b1;
                    end else
`endif
                    begin
                        state        <= ISSUE0;
                        bus.RAMreq   <= 1'b1;
                        bus.RAMwe    <= bus.CPUwe;
                        bus.RAMbe    <= be0;
                        bus.RAMaddr  <= {1'b0, bus.CPUaddr[ADDR_W-1:1]};
                        bus.RAMwrite <= wd0;
                    end
                end
                ISSUE0: begin
                    bus.RAMreq <= 1'b0;
                    bus.RAMwe  <= 1'b0;
                    cnt        <= '0;
                    state      <= WAIT0;
                end
                WAIT0: if (lat_end) begin
                    cnt  <= '0;
                    hi_q <= bus.RAMread[7:0];
                    if (split_q) begin
                        // Second half: next word (wrapping), high lane, low CPU byte.
                        state        <= ISSUE1;
                        bus.RAMreq   <= 1'b1;
                        bus.RAMwe    <= we_q;
                        bus.RAMbe    <= 2'b10;
                        bus.RAMaddr  <= {1'b0, wa_q + WA_W'(1)};
                        bus.RAMwrite <= {wd_q[7:0], 8'h00};
                    end else begin
                        state      <= DONE;
                        bus.CPUack <= 1'b1;
                        if (!we_q) bus.CPUread <= rd_single;
                    end
                end else begin
                    cnt <= cnt + 3'd1;
                end
                ISSUE1: begin
                    bus.RAMreq <= 1'b0;
                    bus.RAMwe  <= 1'b0;
                    cnt        <= '0;
                    state      <= WAIT1;
                end
                WAIT1: if (lat_end) begin
                    state      <= DONE;
                    bus.CPUack <= 1'b1;
                    if (!we_q) bus.CPUread <= {hi_q, bus.RAMread[15:8]};
                end else begin
                    cnt <= cnt + 3'd1;
                end
                DONE: begin
                    state        <= IDLE;
                    bus.CPUack   <= 1'b0;
                    bus.CPUbusy  <= 1'b0;
`ifdef MEM_IO_ALIGN_TRAP_EN
                    bus.CPUfault <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sequential successor to the combinational CPU/RAM byte-lane adapter.
- Converts byte-addressed CPU requests into word-addressed RAM cycles over a req/ack handshake, with a RAM read latency set by a parameter.
- Unaligned 16-bit accesses are split into two RAM cycles, and the address width is parametrised.
- Sits between the CPU core's memory port and the RAM macro.

Parameters:
- ADDR_W, 16: CPU byte-address width; RAM word address is ADDR_W-1 bits, zero-extended to ADDR_W on RAMaddr.
- RAM_LAT, 1: cycles from RAMreq to valid RAMread. Legal range 1..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- CPUreq  in  1  request strobe; sampled only in IDLE.
- CPUwe  in  1  1=write, 0=read.
- CPUbe  in  2  size: 2'b01=byte, any other value=word.
- CPUaddr  in  ADDR_W  byte address.
- CPUwrite  in  16  write data; byte writes use [7:0].
- CPUread  out  16  read data; byte reads zero-extended.
- CPUack  out  1  one-cycle completion pulse.
- CPUbusy  out  1  high whenever state is not IDLE.
- RAMreq  out  1  one-cycle RAM access strobe.
- RAMwe  out  1  write enable; only ever high together with RAMreq.
- RAMbe  out  2  lane enables: [1] is the high byte (even address), [0] is the low byte (odd address).
- RAMaddr  out  ADDR_W  word address, MSB=0.
- RAMwrite  out  16  lane-positioned write data.
- RAMread  in  16  RAM data, valid RAM_LAT cycles after RAMreq.

Behaviour:
- Reset values: all outputs 0; state IDLE; latency counter 0. Reset asserted mid-operation aborts immediately: RAMreq drops, no CPUack is produced, and no second access is issued.
- Byte order is big-endian. Even byte address maps to RAMread[15:8]; odd byte address maps to RAMread[7:0].
- States:
  - IDLE: if CPUreq=1, register we/be/addr/write and go to ISSUE0.
  - ISSUE0: RAMreq=1 for one cycle, then WAIT0.
  - WAIT0: count RAM_LAT cycles, capturing RAMread on the last. If the access is split, go to ISSUE1; otherwise go to DONE.
  - ISSUE1: RAMreq=1 for one cycle, then WAIT1.
  - WAIT1: count RAM_LAT cycles, capturing RAMread on the last, then DONE.
  - DONE: CPUack=1 for one cycle, then IDLE.
- Access classes:
  - Byte, even address A: RAMaddr=A>>1, RAMbe=10, RAMwrite={CPUwrite[7:0],8'h00}; read returns {8'h00,RAMread[15:8]}.
  - Byte, odd address A: RAMaddr=A>>1, RAMbe=01, RAMwrite={8'h00,CPUwrite[7:0]}; read returns {8'h00,RAMread[7:0]}.
  - Word, even address: single access, RAMbe=11, pass-through in both directions.
  - Word, odd address A (split):
    - Access 0: RAMaddr=A>>1, RAMbe=01, write lane[7:0]=CPUwrite[15:8]; read CPUread[15:8]=RAMread[7:0].
    - Access 1: RAMaddr=(A>>1)+1, wrapping modulo 2^(ADDR_W-1), RAMbe=10, write lane[15:8]=CPUwrite[7:0]; read CPUread[7:0]=RAMread[15:8].
- Latency, with CPUreq sampled at cycle T:
  - RAMreq at T+1.
  - Single access: CPUack at T+2+RAM_LAT.
  - Split access: second RAMreq at T+2+RAM_LAT; CPUack at T+3+2*RAM_LAT.
- CPUread is registered. It updates in the CPUack cycle on reads only and holds until the next read ack. Writes leave CPUread unchanged.
- CPUreq while CPUbusy=1 is ignored, not queued. CPUreq high in the DONE cycle is also ignored; back-to-back requests start at earliest one cycle after CPUack.
- RAMaddr, RAMbe, RAMwe and RAMwrite are valid in RAMreq cycles. Between accesses they hold their last value. RAMwe=0 whenever RAMreq=0.
- Unused byte lanes in RAMwrite are driven 0.

Optional Feature:
- MEM_IO_ALIGN_TRAP_EN defined:
  - Adds output CPUfault (1 bit, reset 0).
  - A word access at an odd address issues no RAM cycle; FSM goes IDLE->DONE.
  - CPUack and CPUfault pulse together at T+1; CPUread is unchanged.
- Undefined: no CPUfault port; odd word accesses are split as above.

Test Plan:
- RAM_LAT=1, byte read at 0x0005, RAM word 0x0002=0xA1B2 -> RAMreq at T+1 with RAMaddr=0x0002, RAMbe=01; CPUack at T+3; CPUread=0x00B2.
- Byte write 0x77 to 0x0004 -> single RAMreq with RAMwe=1, RAMaddr=0x0002, RAMbe=10, RAMwrite=0x7700; CPUack at T+3.
- RAM_LAT=2, word read at odd address 0x0007, words 3=0x1122 and 4=0x3344 -> two RAMreq pulses (addr 3 be=01 at T+1, addr 4 be=10 at T+4); CPUack at T+7; CPUread=0x2233.
- Word write 0xBEEF to 0xFFFF with ADDR_W=16 -> access 0: addr 0x7FFF be=01 data 0x00BE; access 1: addr 0x0000 (wrap) be=10 data 0xEF00.
- Reset asserted during WAIT1 of a split access -> RAMreq=0 and state IDLE immediately, no CPUack; CPUreq pulses issued while CPUbusy=1 produce no extra RAM cycles.
- MEM_IO_ALIGN_TRAP_EN defined, word read at 0x0003 -> no RAMreq; CPUack=CPUfault=1 at T+1; CPUread unchanged.
